// File: rtl/dwt_pkg.sv
// Shared types and helpers for the multi-level DWT scheduler.
// The optional DWT_FRAME_CNT_EN macro is consumed by the top module.
package dwt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    REPLAY = 3'd3,
    FINAL  = 3'd4
  } dwt_sched_state_t;

  localparam int DWT_DATA_W    = 16;
  localparam int DWT_FRAME_LEN = 8;
  localparam int DWT_LEVELS    = 3;

  // Number of samples fed to the core at decomposition level lvl
  function automatic int lvl_len(input int frame_len, input int lvl);
    return frame_len >> lvl;
  endfunction

endpackage

// File: rtl/dwt_coef_buf.sv
// Coarse-coefficient store: one synchronous write port, one asynchronous read
// port; a same-cycle read of the address being written returns the old value.
module dwt_coef_buf
  import dwt_pkg::*;
#(
  parameter int DATA_W = DWT_DATA_W,
  parameter int DEPTH  = DWT_FRAME_LEN / 2,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; contents need no reset since every slot is written before read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/dwt_level_scheduler.sv
// Drives a single-level lifting core through LEVELS decomposition levels.
// Define DWT_FRAME_CNT_EN to add the 16-bit frame_count output.
module dwt_level_scheduler
  import dwt_pkg::*;
#(
  parameter int DATA_W    = DWT_DATA_W,
  parameter int FRAME_LEN = DWT_FRAME_LEN,
  parameter int LEVELS    = DWT_LEVELS,
  parameter int LVL_W     = $clog2(LEVELS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid,
  input  logic [DATA_W-1:0] core_detail,
  input  logic [DATA_W-1:0] core_coarse,
  input  logic              core_out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [LVL_W-1:0]  out_level,
  output logic              out_is_coarse,
  output logic              busy
`ifdef DWT_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  localparam int DEPTH = FRAME_LEN / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] N_FINAL_C   = CNT_W'(FRAME_LEN >> LEVELS);
  localparam logic [LVL_W-1:0] LAST_LVL_C  = LVL_W'(LEVELS - 1);

  dwt_sched_state_t  state_r;
  logic [LVL_W-1:0]  level_r;
  logic [CNT_W-1:0]  sample_cnt_r;
  logic [CNT_W-1:0]  pair_cnt_r;
  logic [CNT_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fin_cnt_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [LVL_W-1:0]  out_level_r;
  logic              out_is_coarse_r;
`ifdef DWT_FRAME_CNT_EN
  logic [15:0]       frame_count_r;
`endif

  logic              accept_s;
  logic              pair_valid_s;
  logic              rep_active_s;
  logic              fin_emit_s;
  logic              lvl_end_s;
  logic [CNT_W-1:0]  n_lvl_s;
  logic [CNT_W-1:0]  half_s;
  logic [CNT_W-1:0]  pair_cnt_nx_s;
  logic [AW-1:0]     rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              core_valid_s;
  logic [DATA_W-1:0] core_data_s;

  // Handshake, level bookkeeping and core-input multiplexing
  always_comb begin
    n_lvl_s       = CNT_W'(lvl_len(FRAME_LEN, int'(level_r)));
    half_s        = n_lvl_s >> 1;
    accept_s      = in_valid & in_ready_r;
    pair_valid_s  = core_out_valid &&
                    ((state_r == LOAD) || (state_r == DRAIN) || (state_r == REPLAY));
    pair_cnt_nx_s = pair_valid_s ? (pair_cnt_r + CNT_W'(1)) : pair_cnt_r;
    rep_active_s  = (state_r == REPLAY) && (rd_ptr_r < n_lvl_s);
    fin_emit_s    = (state_r == FINAL) && (fin_cnt_r < N_FINAL_C);
    // Checking the next count also closes a level whose last pair arrived during LOAD
    lvl_end_s     = ((state_r == DRAIN) || (state_r == REPLAY)) && (pair_cnt_nx_s == half_s);
    if (state_r == FINAL) begin
      rd_addr_s = fin_cnt_r[AW-1:0];
    end else begin
      rd_addr_s = rd_ptr_r[AW-1:0];
    end
    core_valid_s = accept_s | rep_active_s;
    if (accept_s) begin
      core_data_s = in_data;
    end else if (rep_active_s) begin
      core_data_s = rd_data_s;
    end else begin
      core_data_s = {DATA_W{1'b0}};
    end
  end

  dwt_coef_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (pair_valid_s),
    .wr_addr (pair_cnt_r[AW-1:0]),
    .wr_data (core_coarse),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Scheduler FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= IDLE;
      level_r         <= {LVL_W{1'b0}};
      sample_cnt_r    <= {CNT_W{1'b0}};
      pair_cnt_r      <= {CNT_W{1'b0}};
      rd_ptr_r        <= {CNT_W{1'b0}};
      fin_cnt_r       <= {CNT_W{1'b0}};
      in_ready_r      <= 1'b1;
      busy_r          <= 1'b0;
      out_valid_r     <= 1'b0;
      out_data_r      <= {DATA_W{1'b0}};
      out_level_r     <= {LVL_W{1'b0}};
      out_is_coarse_r <= 1'b0;
`ifdef DWT_FRAME_CNT_EN
      frame_count_r   <= 16'd0;
`endif
    end else begin
      out_valid_r <= 1'b0;
      if (pair_valid_s) begin
        out_valid_r     <= 1'b1;
        out_data_r      <= core_detail;
        out_level_r     <= level_r;
        out_is_coarse_r <= 1'b0;
      end else if (fin_emit_s) begin
        out_valid_r     <= 1'b1;
        out_data_r      <= rd_data_s;
        out_level_r     <= LAST_LVL_C;
        out_is_coarse_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r      <= LOAD;
            sample_cnt_r <= CNT_W'(1);
            level_r      <= {LVL_W{1'b0}};
            pair_cnt_r   <= {CNT_W{1'b0}};
            busy_r       <= 1'b1;
          end
        end
        LOAD: begin
          pair_cnt_r <= pair_cnt_nx_s;
          if (accept_s) begin
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            if ((sample_cnt_r + CNT_W'(1)) == FRAME_LEN_C) begin
              state_r    <= DRAIN;
              in_ready_r <= 1'b0;
            end
          end
        end
        DRAIN, REPLAY: begin
          if (lvl_end_s) begin
            pair_cnt_r <= {CNT_W{1'b0}};
            rd_ptr_r   <= {CNT_W{1'b0}};
            fin_cnt_r  <= {CNT_W{1'b0}};
            level_r    <= level_r + LVL_W'(1);
            state_r    <= (level_r == LAST_LVL_C) ? FINAL : REPLAY;
          end else begin
            pair_cnt_r <= pair_cnt_nx_s;
            if (rep_active_s) begin
              rd_ptr_r <= rd_ptr_r + CNT_W'(1);
            end
          end
        end
        FINAL: begin
          // The extra cycle holds busy high while the last coarse is on the output
          if (fin_cnt_r == N_FINAL_C) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
`ifdef DWT_FRAME_CNT_EN
            frame_count_r <= frame_count_r + 16'd1;
`endif
          end else begin
            fin_cnt_r <= fin_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_r;
  assign busy          = busy_r;
  assign core_valid    = core_valid_s;
  assign core_data     = core_data_s;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_level     = out_level_r;
  assign out_is_coarse = out_is_coarse_r;
`ifdef DWT_FRAME_CNT_EN
  assign frame_count   = frame_count_r;
`endif

endmodule

// File: tb/tb_dwt_level_scheduler.sv
// Scoreboard bench for dwt_level_scheduler with an integer Haar core model.
module tb_dwt_level_scheduler;
  import dwt_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] core_data;
  logic        core_valid;
  logic [15:0] core_detail;
  logic [15:0] core_coarse;
  logic        core_out_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  out_level;
  logic        out_is_coarse;
  logic        busy;
`ifdef DWT_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  lvl;
    logic        c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic saw_coarse = 1'b0;
  logic force_cov  = 1'b0;

  logic        mdl_ov;
  logic        mdl_phase;
  logic [15:0] mdl_even;

  dwt_level_scheduler #(.DATA_W(16), .FRAME_LEN(8), .LEVELS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .core_data      (core_data),
    .core_valid     (core_valid),
    .core_detail    (core_detail),
    .core_coarse    (core_coarse),
    .core_out_valid (core_out_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_level      (out_level),
    .out_is_coarse  (out_is_coarse),
    .busy           (busy)
`ifdef DWT_FRAME_CNT_EN
    ,
    .frame_count    (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] haar_c(input logic [15:0] ev, input logic [15:0] od);
    logic signed [15:0] d;
    d = $signed(od - ev);
    return ev + 16'(d >>> 1);
  endfunction

  // Integer Haar core: pair output one cycle after the odd sample
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_ov      <= 1'b0;
      mdl_phase   <= 1'b0;
      mdl_even    <= 16'd0;
      core_detail <= 16'd0;
      core_coarse <= 16'd0;
    end else begin
      mdl_ov <= 1'b0;
      if (core_valid) begin
        if (!mdl_phase) begin
          mdl_even  <= core_data;
          mdl_phase <= 1'b1;
        end else begin
          core_detail <= core_data - mdl_even;
          core_coarse <= haar_c(mdl_even, core_data);
          mdl_ov      <= 1'b1;
          mdl_phase   <= 1'b0;
        end
      end
    end
  end

  assign core_out_valid = mdl_ov | force_cov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [1:0] l, input logic c);
    exp_t e;
    e.d = d; e.lvl = l; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data=%0h level=%0d coarse=%0b with nothing expected",
                   out_data, out_level, out_is_coarse);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_level", out_level, e.lvl);
          chk("out_is_coarse", out_is_coarse, e.c);
          if (out_is_coarse) saw_coarse = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] s[8], input bit toggle);
    int i = 0;
    int g = 0;
    while (i < 8 && g < 100) begin
      @(negedge clk);
      g++;
      if (toggle && (g % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = s[i];
      end
      #1;
      chk("in_ready_load", in_ready, 1'b1);
      chk("core_valid_pass", core_valid, in_valid);
      if (in_valid) chk("core_data_pass", core_data, in_data);
      @(posedge clk);
      if (in_valid && in_ready) i++;
    end
    chk("send_timeout", i, 8);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      if (busy) chk("in_ready_busy", in_ready, 1'b0);
      n++;
    end while (busy && n < 200);
    chk("done_timeout", busy, 1'b0);
    chk("coarse_before_idle", saw_coarse, 1'b1);
    chk("in_ready_idle", in_ready, 1'b1);
    chk("queue_drained", exp_q.size(), 0);
    saw_coarse = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_core_valid"}, core_valid, 1'b0);
    chk({tag, "_core_data"}, core_data, 16'd0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 16'd0);
    chk({tag, "_out_level"}, out_level, 2'd0);
    chk({tag, "_out_is_coarse"}, out_is_coarse, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  logic [15:0] f1[8]   = '{16'd1, 16'd5, 16'd6, 16'd9, 16'd12, 16'd16, 16'd18, 16'd22};
  logic [15:0] f2[8]   = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
  logic [15:0] e1_d[8] = '{16'd4, 16'd3, 16'd4, 16'd4, 16'd4, 16'd6, 16'd12, 16'd11};
  logic [1:0]  e_l[8]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};

  task automatic push_f1(input int count);
    for (int k = 0; k < count; k++) push_exp(e1_d[k], e_l[k], (k == 7));
  endtask

  task automatic push_f2();
    for (int k = 0; k < 8; k++) push_exp((k == 7) ? 16'd2 : 16'd0, e_l[k], (k == 7));
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_rst");
`ifdef DWT_FRAME_CNT_EN
    chk("frame_count_rst", frame_count, 16'd0);
`endif

    // Continuous frame
    push_f1(8);
    send_frame(f1, 1'b0);
    wait_done();

    // Same frame with gaps on in_valid
    push_f1(8);
    send_frame(f1, 1'b1);
    wait_done();

    // Back-to-back identical frames from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int fr = 1; fr <= 2; fr++) begin
      push_f1(8);
      send_frame(f1, 1'b0);
      wait_done();
`ifdef DWT_FRAME_CNT_EN
      @(negedge clk);
      chk("frame_count_step", frame_count, 16'(fr));
`endif
    end

    // Abort during level-1 replay, then a constant frame
    push_f1(5);
    send_frame(f1, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("abort_wait_timeout", exp_q.size(), 0);
    rst = 1'b0;
    #1;
    chk_reset_outs("abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_outs("abort_idle");
    saw_coarse = 1'b0;
    push_f2();
    send_frame(f2, 1'b0);
    wait_done();

    // Spurious core output pulse while idle
    @(negedge clk);
    force_cov = 1'b1;
    @(negedge clk);
    force_cov = 1'b0;
    chk("idle_pulse_busy", busy, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_pulse_out_valid", out_valid, 1'b0);
      chk("idle_pulse_in_ready", in_ready, 1'b1);
      chk("idle_pulse_busy_hold", busy, 1'b0);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dwt_level_scheduler.md
Name: dwt_level_scheduler

Overview:
Sequences the single-level lifting core (data/valid in; detail/coarse out) through LEVELS decomposition levels on a frame of FRAME_LEN samples. The block forwards level-0 input samples to the core and stores each coarse output in an internal buffer. It replays that buffer into the core for each subsequent level, emitting level-tagged detail coefficients and, at the end, the final coarse coefficients. It sits between the sample source and the lifting core `top`.

Parameters:
DATA_W, 16, sample and coefficient width
FRAME_LEN, 8, samples per frame; power of two, ≥ 2^LEVELS
LEVELS, 3, decomposition levels, ≥1
LVL_W, $clog2(LEVELS+1), width of level tag

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_data  in  DATA_W  input sample
in_valid  in  1  input sample valid
in_ready  out  1  scheduler accepts sample this cycle
core_data  out  DATA_W  sample to lifting core
core_valid  out  1  core input valid
core_detail  in  DATA_W  core detail coefficient
core_coarse  in  DATA_W  core coarse coefficient
core_out_valid  in  1  core output pair valid (one per two inputs)
out_data  out  DATA_W  emitted coefficient
out_valid  out  1  out_data valid (no backpressure)
out_level  out  LVL_W  level of emitted coefficient (0-based)
out_is_coarse  out  1  1 = final coarse coefficient, 0 = detail
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0. Outputs in_ready=1, core_valid=0, core_data=0, out_valid=0, out_data=0, out_level=0, out_is_coarse=0, busy=0. Buffer contents are don't-care.
- States: IDLE, LOAD, DRAIN, REPLAY, FINAL.
- IDLE: in_ready=1. An in_valid handshake enters LOAD, with the sample counted as sample 0 and forwarded.
- LOAD: in_ready=1. Each in_valid&in_ready drives core_data=in_data, core_valid=1 in the same cycle (combinational pass-through, registered core_valid not allowed). Gaps in in_valid are allowed. After FRAME_LEN accepted samples, in_ready drops and the block goes to DRAIN.
- Level L input length is N_L = FRAME_LEN>>L. The level expects N_L/2 core output pairs.
- Every core_out_valid in LOAD, DRAIN or REPLAY:
  - Write core_coarse to buf[pair_cnt].
  - Emit core_detail on out_* the next cycle (registered): out_level=L, out_is_coarse=0.
  - Increment pair_cnt.
- DRAIN/REPLAY level end: when pair_cnt reaches N_L/2, reset pair_cnt and increment L.
  - If L becomes LEVELS, go to FINAL.
  - Otherwise go to REPLAY, with the read pointer at 0.
- REPLAY: read buf[rd_ptr] and drive core_valid=1 each cycle until N_L samples are sent; then core_valid=0, wait for pairs, same end rule.
  - In-place is safe: write index k occurs only after read index 2k+1 ≥ k.
  - Simultaneous read and write of the same index returns the old value.
- FINAL: emit buf[0..(FRAME_LEN>>LEVELS)-1], one per cycle, with out_is_coarse=1 and out_level=LEVELS-1. Then return to IDLE; in_ready rises the cycle after the last coarse is emitted.
- core_out_valid in IDLE or FINAL is ignored.
- Excess pairs beyond N_L/2 cannot occur: the level switches on the exact count.
- Arithmetic: none on data; coefficients pass through unmodified at DATA_W.
- Counters are sized $clog2(FRAME_LEN)+1; no wrap within a frame.
- rst asserted mid-frame aborts immediately; the partial frame is discarded with no further outputs.

Optional Feature:
DWT_FRAME_CNT_EN:
- Defined: adds output port frame_count (16 bits), reset 0. It increments the cycle after a frame's last FINAL coarse is emitted and wraps at 16'hFFFF→0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package dwt_pkg: state enum dwt_sched_state_t {IDLE, LOAD, DRAIN, REPLAY, FINAL}, DATA_W default constant, and function lvl_len(L) = FRAME_LEN>>L.
- One sub-module, dwt_coef_buf: a DATA_W × FRAME_LEN/2 register array with 1 write port, 1 async-read port and read-old-on-collision semantics.
- FSM and counters stay in dwt_level_scheduler.

Test Plan:
Common setup: FRAME_LEN=8, LEVELS=3. The bench core model is integer Haar: d=odd−even, c=even+(d>>>1), output one cycle after the odd sample.
- Frame 1,5,6,9,12,16,18,22 with in_valid continuous:
  - L0 details 4,3,4,4.
  - L1 details 4,6.
  - L2 detail 12.
  - Final coarse 11 (out_is_coarse=1, out_level=2).
  - busy falls after the coarse output; in_ready=0 from the 9th cycle until return to IDLE.
- Same frame with in_valid toggling every other cycle: identical output sequence; core_valid pulses only on accepted samples.
- Two back-to-back frames (the second identical): the second frame's outputs equal the first's.
  - With DWT_FRAME_CNT_EN defined, frame_count steps 0→1→2.
- Assert rst low during REPLAY of L1, release, then send frame 2,2,2,2,2,2,2,2:
  - No stale outputs.
  - All details 0; final coarse 2.
- Pulse core_out_valid while in IDLE: no out_valid and no state change; busy stays 0.
